// File: rtl/operand_handler_pipe_if.sv
// Operand handler bus: request side (RB, immediate, mode), SAR write port
// and result side (N, error flag), with valid/ready on both ends.
interface operand_handler_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 21
);
    localparam int SHAMT_W = $clog2(DATA_W);

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   rb;
    logic [IMM_W-1:0]    imm;
    logic [3:0]          sel;
    logic                sar_we;
    logic [SHAMT_W-1:0]  sar_wdata;
    logic [SHAMT_W-1:0]  sar_q;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   n;
    logic                out_err;

    // Producer / consumer side (register-file read stage and ALU)
    modport master (
        output in_valid, rb, imm, sel, sar_we, sar_wdata, out_ready,
        input  in_ready, sar_q, out_valid, n, out_err
    );

    // Operand handler side
    modport slave (
        input  in_valid, rb, imm, sel, sar_we, sar_wdata, out_ready,
        output in_ready, sar_q, out_valid, n, out_err
    );
endinterface

// File: rtl/operand_handler_pipe.sv
// Two-stage valid/ready operand handler for the PA-RISC execute path.
// Stage 1 captures RB, the immediate, the mode and a snapshot of SAR;
// the mode decode and shifting happen between stage 1 and stage 2, and
// stage 2 holds the ALU's second operand N plus an illegal-mode flag.
module operand_handler_pipe #(
    parameter int  DATA_W  = 32,
    parameter int  IMM_W   = 21,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input logic                   clk,
    input logic                   reset,
    operand_handler_pipe_if.slave bus
);

    // Shift distance for fixed-shift modes is (DATA_W-1) - imm field,
    // wrapping naturally in SHAMT_W bits.
    localparam logic [SHAMT_W-1:0] MAX_SH = SHAMT_W'(DATA_W - 1);

    localparam logic [3:0] SEL_RB      = 4'd0;
    localparam logic [3:0] SEL_IMM11   = 4'd1;
    localparam logic [3:0] SEL_IMM14   = 4'd2;
    localparam logic [3:0] SEL_IMM_HI  = 4'd3;
    localparam logic [3:0] SEL_SRL_IMM = 4'd4;
    localparam logic [3:0] SEL_SRA_IMM = 4'd5;
    localparam logic [3:0] SEL_SLL_IMM = 4'd6;
    localparam logic [3:0] SEL_ZERO    = 4'd7;
    localparam logic [3:0] SEL_SRL_SAR = 4'd8;
    localparam logic [3:0] SEL_SRA_SAR = 4'd9;
    localparam logic [3:0] SEL_SLL_SAR = 4'd10;

    // Stage 1 registers
    logic                r_s1_valid;
    logic [DATA_W-1:0]   r_s1_rb;
    logic [IMM_W-1:0]    r_s1_imm;
    logic [3:0]          r_s1_sel;
    logic [SHAMT_W-1:0]  r_s1_sar;

    // Stage 2 registers (drive the outputs directly)
    logic                r_s2_valid;
    logic [DATA_W-1:0]   r_n;
    logic                r_err;

    // Shift amount register
    logic [SHAMT_W-1:0]  r_sar;

    // Handshake and datapath wires
    logic                       w_s2_ready;
    logic                       w_s1_ready;
    logic                       w_accept;
    logic [SHAMT_W-1:0]         w_fsh;
    logic signed [DATA_W-1:0]   w_rb_signed;
    logic [DATA_W-1:0]          w_imm_sx11;
    logic [DATA_W-1:0]          w_imm_sx14;
    logic [DATA_W-1:0]          w_imm_hi;
    logic [DATA_W-1:0]          w_n;
    logic                       w_err;

    // A stage can take new data when it is empty or its content moves on
    // this cycle; in_ready therefore follows out_ready combinationally.
    assign w_s2_ready = !r_s2_valid || bus.out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_accept   = bus.in_valid && w_s1_ready;

    assign w_fsh       = MAX_SH - r_s1_imm[SHAMT_W+4:5];
    assign w_rb_signed = r_s1_rb;
    assign w_imm_sx11  = {{(DATA_W-10){r_s1_imm[10]}}, r_s1_imm[9:0]};
    assign w_imm_sx14  = {{(DATA_W-13){r_s1_imm[13]}}, r_s1_imm[12:0]};
    assign w_imm_hi    = DATA_W'(r_s1_imm) << (DATA_W - IMM_W);

    // Mode decode: form N from the stage-1 snapshot; unused modes give 0 with error
    always_comb begin
        w_n   = '0;
        w_err = 1'b0;
        case (r_s1_sel)
            SEL_RB:      w_n = r_s1_rb;
            SEL_IMM11:   w_n = w_imm_sx11;
            SEL_IMM14:   w_n = w_imm_sx14;
            SEL_IMM_HI:  w_n = w_imm_hi;
            SEL_SRL_IMM: w_n = r_s1_rb >> w_fsh;
            SEL_SRA_IMM: w_n = w_rb_signed >>> w_fsh;
            SEL_SLL_IMM: w_n = r_s1_rb << w_fsh;
            SEL_ZERO:    w_n = '0;
            SEL_SRL_SAR: w_n = r_s1_rb >> r_s1_sar;
            SEL_SRA_SAR: w_n = w_rb_signed >>> r_s1_sar;
            SEL_SLL_SAR: w_n = r_s1_rb << r_s1_sar;
            default: begin
                w_n   = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // SAR: written whenever sar_we is set, regardless of the pipeline handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sar <= '0;
        end else if (bus.sar_we) begin
            r_sar <= bus.sar_wdata;
        end
    end

    // Stage 1: capture the request and the SAR value as it stood before this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_rb    <= '0;
            r_s1_imm   <= '0;
            r_s1_sel   <= 4'd0;
            r_s1_sar   <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_rb  <= bus.rb;
                r_s1_imm <= bus.imm;
                r_s1_sel <= bus.sel;
                r_s1_sar <= r_sar;
            end
        end
    end

    // Stage 2: register the decoded operand; hold everything while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_n        <= '0;
            r_err      <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_n   <= w_n;
                r_err <= w_err;
            end
        end
    end

    assign bus.in_ready  = w_s1_ready;
    assign bus.sar_q     = r_sar;
    assign bus.out_valid = r_s2_valid;
    assign bus.n         = r_n;
    assign bus.out_err   = r_err;

endmodule
